// File: rtl/apb3_initiator_bridge_pkg.sv
// Shared APB3 definitions: transfer FSM states, response status and the
// default bus widths used by the initiator bridge and the peripheral slaves.
package apb3_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 16;
    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic err;
        logic timeout;
    } rsp_status_t;

endpackage

// File: rtl/apb3_initiator_bridge_if.sv
// Bundle of the bridge's host command/response channels and APB3 bus.
//   cmd_*   : host command stream (valid/ready)
//   rsp_*   : response stream (valid/ready) with read data and status
//   P*      : APB3 requester signals
// master modport is the bridge's view; slave modport is the host/fabric view.
interface apb3_initiator_bridge_if
    import apb3_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb3_initiator_bridge_timeout_counter.sv
// ACCESS-phase wait counter.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : return count to 0
//   enable      : count one more wait cycle (saturating)
//   last        : high when one more enabled cycle reaches TIMEOUT_CYCLES;
//                 never high when TIMEOUT_CYCLES is 0 (timeout disabled)
module apb3_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] LAST_VAL =
        TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] SAT_VAL =
        TMO_EN ? CNT_W'(TIMEOUT_CYCLES) : '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != SAT_VAL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded one cycle early so the FSM can leave ACCESS on the cycle the
    // count reaches the limit, letting a same-cycle PREADY take priority.
    assign last = TMO_EN && (cnt_q == LAST_VAL);

endmodule

// File: rtl/apb3_initiator_bridge.sv
// Single-outstanding APB3 initiator. Accepts one command on the cmd channel,
// runs an APB3 SETUP/ACCESS transfer, and returns read data plus error and
// timeout status on the rsp channel. All outputs are registered.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : command, response and APB3 signals (master modport)
module apb3_initiator_bridge
    import apb3_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    apb3_initiator_bridge_if.master bus
);
    apb_state_e            state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    rsp_status_t           status_q, status_d;

    logic tmo_clear;
    logic tmo_en;
    logic tmo_last;

    apb3_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .resetn (resetn),
        .clear  (tmo_clear),
        .enable (tmo_en),
        .last   (tmo_last)
    );

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        status_d    = status_q;
        tmo_clear   = 1'b0;
        tmo_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                tmo_clear = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    status_d    = '{err: bus.PSLVERR, timeout: 1'b0};
                    state_d     = RESP;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_last) begin
                        rsp_rdata_d = '0;
                        status_d    = '{err: 1'b1, timeout: 1'b1};
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear as flops.
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            status_q    <= status_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = status_q.err;
    assign bus.rsp_timeout = status_q.timeout;

endmodule
